// File: rtl/adder_16bit.sv
// Registered 16-bit ripple-carry adder with sign/zero/carry/parity/overflow flags.
// Latency 1 cycle (2 cycles when ADDER16_INREG_EN is defined, adding an input register stage).
// No backpressure: a new operand pair is accepted every cycle.
module adder_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] z,
  output logic        sign,
  output logic        zero,
  output logic        carry,
  output logic        parity,
  output logic        overflow
);

  // One full adder: returns {cout, s}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  // 4-bit ripple block of four full adders: returns {cout, sum[3:0]}.
  function automatic logic [4:0] rca4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] sum;
    logic       c;
    logic [1:0] r;
    sum = '0;
    c   = cin;
    for (int i = 0; i < 4; i++) begin
      r      = fa(a[i], b[i], c);
      sum[i] = r[0];
      c      = r[1];
    end
    return {c, sum};
  endfunction

  logic [15:0] xa;
  logic [15:0] ya;
  logic        cap;

`ifdef ADDER16_INREG_EN
  logic [15:0] xr;
  logic [15:0] yr;
  logic        in_vld;

  // Input stage; in_vld keeps the first post-reset output all-zero rather than 0+0 flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr     <= '0;
      yr     <= '0;
      in_vld <= 1'b0;
    end else begin
      xr     <= x;
      yr     <= y;
      in_vld <= 1'b1;
    end
  end

  assign xa  = xr;
  assign ya  = yr;
  assign cap = in_vld;
`else
  assign xa  = x;
  assign ya  = y;
  assign cap = 1'b1;
`endif

  logic [15:0] s;
  logic        c4;
  logic        c8;
  logic        c12;
  logic        c16;

  // Four cascaded ripple blocks; carry-in of bit 0 is zero.
  always_comb begin
    {c4,  s[3:0]}   = rca4(xa[3:0],   ya[3:0],   1'b0);
    {c8,  s[7:4]}   = rca4(xa[7:4],   ya[7:4],   c4);
    {c12, s[11:8]}  = rca4(xa[11:8],  ya[11:8],  c8);
    {c16, s[15:12]} = rca4(xa[15:12], ya[15:12], c12);
  end

  logic sign_c;
  logic zero_c;
  logic parity_c;
  logic ovf_c;

  assign sign_c   = s[15];
  assign zero_c   = ~|s;
  assign parity_c = ~^s;
  assign ovf_c    = (xa[15] & ya[15] & ~s[15]) | (~xa[15] & ~ya[15] & s[15]);

  // Output register: reset (or an empty input stage) forces every output to zero.
  always_ff @(posedge clk) begin
    if (rst || !cap) begin
      z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      z        <= s;
      sign     <= sign_c;
      zero     <= zero_c;
      carry    <= c16;
      parity   <= parity_c;
      overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_adder_16bit.sv
// Scoreboard bench for adder_16bit: directed corner vectors, random back-to-back stream, mid-stream reset.
// Expected results come from plain integer arithmetic on the operands.
// Monitor pops one expectation per cycle and compares at the falling edge.
module tb_adder_16bit;

`ifdef ADDER16_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;

  adder_16bit dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .z        (z),
    .sign     (sign),
    .zero     (zero),
    .carry    (carry),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected packing: {z[15:0], sign, zero, carry, parity, overflow}
  typedef struct {
    int          due;
    logic [20:0] val;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  function automatic logic [20:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int unsigned u;
    int          sa;
    int          sb;
    int          r;
    logic [15:0] zz;
    logic        f_sign, f_zero, f_carry, f_par, f_ovf;
    u  = int'(a) + int'(b);
    sa = $signed(a);
    sb = $signed(b);
    r  = sa + sb;
    zz = 16'(u % 65536);
    f_sign  = (zz >= 16'h8000);
    f_zero  = (zz == 16'h0000);
    f_carry = (u > 65535);
    f_par   = (($countones(zz) % 2) == 0);
    f_ovf   = (r > 32767) || (r < -32768);
    return {zz, f_sign, f_zero, f_carry, f_par, f_ovf};
  endfunction

  // History of the previous edge's drive, for the two-stage build.
  logic        prev_rst = 1'b1;
  logic [15:0] prev_x   = '0;
  logic [15:0] prev_y   = '0;

  // Drive one edge's worth of inputs and queue the output expected right after that edge.
  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    x   = a;
    y   = b;
    e.due = cyc + 1;
    if (LAT == 1) begin
      e.a   = a;
      e.b   = b;
      e.val = r ? 21'd0 : ref_add(a, b);
    end else begin
      e.a   = prev_x;
      e.b   = prev_y;
      e.val = (r || prev_rst) ? 21'd0 : ref_add(prev_x, prev_y);
    end
    exp_q.push_back(e);
    prev_rst = r;
    prev_x   = a;
    prev_y   = b;
  endtask

  // Monitor: compares the DUT outputs against the queued expectation due this cycle.
  always @(negedge clk) begin
    logic [20:0] act;
    act = {z, sign, zero, carry, parity, overflow};
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_checks++;
      $display("FAIL missed_result x=%h y=%h due=%0d now=%0d", exp_q[0].a, exp_q[0].b, exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      n_checks++;
      if (act === exp_q[0].val) begin
        n_pass++;
      end else begin
        $display("FAIL add x=%h y=%h got z=%h s%b z%b c%b p%b o%b want z=%h s%b z%b c%b p%b o%b",
                 exp_q[0].a, exp_q[0].b, act[20:5], act[4], act[3], act[2], act[1], act[0],
                 exp_q[0].val[20:5], exp_q[0].val[4], exp_q[0].val[3], exp_q[0].val[2],
                 exp_q[0].val[1], exp_q[0].val[0]);
      end
      void'(exp_q.pop_front());
    end
  end

  logic [15:0] dir_x [10];
  logic [15:0] dir_y [10];

  initial begin
    int budget;
    rst = 1'b1;
    x   = '0;
    y   = '0;
    dir_x = '{16'h8fff, 16'hfffe, 16'haaaa, 16'h7fff, 16'h0000,
              16'hffff, 16'h8000, 16'hffff, 16'h0001, 16'h7fff};
    dir_y = '{16'h8000, 16'h0002, 16'h5555, 16'h0001, 16'h0000,
              16'h0001, 16'h8000, 16'hffff, 16'h0000, 16'h7fff};

    // Reset with nonzero operands present: outputs must read all-zero.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hffff, 16'h0001);

    // Directed corner vectors, back-to-back.
    for (int i = 0; i < 10; i++) drive(1'b0, dir_x[i], dir_y[i]);

    // Random back-to-back stream.
    for (int i = 0; i < 200; i++) drive(1'b0, 16'($urandom), 16'($urandom));

    // Streaming 1234+1111 with a one-cycle reset in the middle.
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h1234, 16'h1111);
    drive(1'b1, 16'h1234, 16'h1111);
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h1234, 16'h1111);

    // Random stream with occasional resets.
    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 19) == 0), 16'($urandom), 16'($urandom));

    stim_done = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
